// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: burst sequencer state
//   encoding, read-return owner tag encoding, default parameter values and
//   a saturating counter helper used by the starvation counter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_LEN_W    = 10;
    localparam int DEF_MAX_WAIT = 4;
    localparam int WAIT_W       = 4;   // holds MAX_WAIT up to 15

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } burst_state_e;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    // Increment v, holding at lim once reached.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v,
                                                  input logic [WAIT_W-1:0] lim);
        logic [WAIT_W-1:0] res;
        if (v >= lim) begin
            res = lim;
        end else begin
            res = v + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the arbiter:
//     cpu_*   MEM-stage load/store port (byte address, stall, read return)
//     host_*  host command handshake, write-beat handshake, read beats, done
//     mem_*   single-port synchronous data memory (1-cycle read latency)
//   slave  : the arbiter's view
//   master : the view of the requesters and the memory array
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
);
    logic              cpu_req;
    logic              cpu_wr;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic [31:0]       cpu_rdata;
    logic              cpu_rvalid;

    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic              host_cmd_wr;
    logic [ADDR_W-1:0] host_cmd_addr;
    logic [LEN_W-1:0]  host_cmd_len;
    logic [31:0]       host_wdata;
    logic              host_wvalid;
    logic              host_wready;
    logic [31:0]       host_rdata;
    logic              host_rvalid;
    logic              host_done;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_cmd_valid, host_cmd_wr, host_cmd_addr, host_cmd_len,
        input  host_wdata, host_wvalid,
        output host_cmd_ready, host_wready, host_rdata, host_rvalid, host_done,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_cmd_valid, host_cmd_wr, host_cmd_addr, host_cmd_len,
        output host_wdata, host_wvalid,
        input  host_cmd_ready, host_wready, host_rdata, host_rvalid, host_done,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_burst_seq.sv
// dmem_burst_seq
//   Host burst sequencer: accepts a command in IDLE, walks the word address
//   and remaining-beat count on every host grant during BURST, and spends
//   one cycle in DONE to signal completion.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     i_cmd_valid/wr/addr/len       host command fields
//     i_grant                       host won the memory slot this cycle
//     o_idle                        FSM in IDLE (command can be accepted)
//     o_busy                        FSM in BURST (host may want slots)
//     o_burst_wr                    latched burst direction
//     o_addr                        current burst word address
//     o_done                        completion pulse (FSM in DONE)
module dmem_burst_seq
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    input  logic              i_cmd_wr,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_grant,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_burst_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_done
);

    burst_state_e      r_state;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;

    // Burst FSM with address / remaining-count bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_wr    <= i_cmd_wr;
                        r_addr  <= i_cmd_addr;
                        r_rem   <= i_cmd_len;
                        r_state <= (i_cmd_len == '0) ? DONE : BURST;
                    end
                end
                BURST: begin
                    if (i_grant) begin
                        // Address wraps naturally at 2^ADDR_W.
                        r_addr <= r_addr + ADDR_W'(1);
                        r_rem  <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_idle     = (r_state == IDLE);
    assign o_busy     = (r_state == BURST);
    assign o_done     = (r_state == DONE);
    assign o_burst_wr = r_wr;
    assign o_addr     = r_addr;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port synchronous data memory between the CPU MEM stage
//   (priority requester) and a host burst port. A starvation counter lets
//   the host take one slot after MAX_WAIT consecutive lost cycles.
//   Ports:
//     clk, rst   clock, async active-high reset
//     bus        dmem_arbiter_if.slave: cpu_*, host_*, mem_* buses
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
)(
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic              w_idle;
    logic              w_busy;
    logic              w_burst_wr;
    logic [ADDR_W-1:0] w_host_addr;
    logic              w_host_want;
    logic              w_cpu_grant;
    logic              w_host_grant;
    logic              w_rd_grant;
    logic              w_unused_addr_bits;

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_owner;
    logic              r_rvalid;

    dmem_burst_seq #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (bus.host_cmd_valid),
        .i_cmd_wr    (bus.host_cmd_wr),
        .i_cmd_addr  (bus.host_cmd_addr),
        .i_cmd_len   (bus.host_cmd_len),
        .i_grant     (w_host_grant),
        .o_idle      (w_idle),
        .o_busy      (w_busy),
        .o_burst_wr  (w_burst_wr),
        .o_addr      (w_host_addr),
        .o_done      (bus.host_done)
    );

    // Grant decision: CPU first unless the host has been starved long enough.
    always_comb begin
        w_host_want  = w_busy & (~w_burst_wr | bus.host_wvalid);
        w_cpu_grant  = ~rst & bus.cpu_req &
                       ~(w_host_want & (r_wait_cnt == L_MAX_WAIT));
        w_host_grant = ~rst & w_host_want & ~w_cpu_grant;
    end

    // Memory port mux driven by whichever requester was granted.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'd0;
        if (w_cpu_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.cpu_wdata;
        end else if (w_host_grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = w_burst_wr;
            bus.mem_addr  = w_host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else begin
            bus.mem_en    = 1'b0;
        end
    end

    assign w_rd_grant = bus.mem_en & ~bus.mem_wr;

    // Starvation counter plus owner tag for the one-cycle-late read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_owner    <= OWN_CPU;
            r_rvalid   <= 1'b0;
        end else begin
            if (w_host_want & ~w_host_grant) begin
                r_wait_cnt <= sat_inc(r_wait_cnt, L_MAX_WAIT);
            end else begin
                r_wait_cnt <= '0;
            end
            r_rvalid <= w_rd_grant;
            if (w_rd_grant) begin
                r_owner <= w_host_grant ? OWN_HOST : OWN_CPU;
            end else begin
                r_owner <= r_owner;
            end
        end
    end

    assign bus.host_cmd_ready = w_idle & ~rst;
    assign bus.cpu_stall      = bus.cpu_req & ~w_cpu_grant;
    assign bus.host_wready    = w_host_grant & w_burst_wr;
    assign bus.cpu_rvalid     = r_rvalid & (r_owner == OWN_CPU);
    assign bus.host_rvalid    = r_rvalid & (r_owner == OWN_HOST);
    assign bus.cpu_rdata      = bus.mem_rdata;
    assign bus.host_rdata     = bus.mem_rdata;

    // Byte-offset and above-range address bits are not used by the memory.
    assign w_unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench with a scoreboard: stimulus pushes expected memory
//   accesses and read returns into queues; a negedge monitor pops and
//   compares whenever the DUT presents mem_en, cpu_rvalid or host_rvalid.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 10;
    localparam int LW = 10;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .LEN_W(LW), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    acc_t        q_mem[$];
    logic [31:0] q_crd[$];
    logic [31:0] q_hrd[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem [0:1023];

    // Memory array: word i starts as A500_0000 | i.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h with nothing expected at %0t", nm, act, $time);
    endtask

    task automatic exp_acc(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.wdata = d;
        q_mem.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        acc_t        e;
        logic [31:0] d;
        if (bus.mem_en === 1'b1) begin
            if (q_mem.size() == 0) begin
                unexpected("mem_access", 32'(bus.mem_addr));
            end else begin
                e = q_mem.pop_front();
                chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wdata);
            end
        end
        if (bus.cpu_rvalid !== 1'b0) begin
            if (q_crd.size() == 0) unexpected("cpu_rvalid", bus.cpu_rdata);
            else begin d = q_crd.pop_front(); chk("cpu_rdata", bus.cpu_rdata, d); end
        end
        if (bus.host_rvalid !== 1'b0) begin
            if (q_hrd.size() == 0) unexpected("host_rvalid", bus.host_rdata);
            else begin d = q_hrd.pop_front(); chk("host_rdata", bus.host_rdata, d); end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   wd [4];
        logic [AW-1:0] wa [4];
        logic          hs;
        wd = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000D};
        wa = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);

        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.host_cmd_valid = 1'b0; bus.host_cmd_wr = 1'b0; bus.host_cmd_addr = 10'd0;
        bus.host_cmd_len = 10'd0; bus.host_wdata = 32'd0; bus.host_wvalid = 1'b0;

        // Reset state: no grants, stall follows cpu_req.
        bus.cpu_req = 1'b1;
        #2;
        chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_cmd_ready", 32'(bus.host_cmd_ready), 32'd0);
        chk("rst_host_done", 32'(bus.host_done), 32'd0);
        chk("rst_rvalid", 32'({bus.cpu_rvalid, bus.host_rvalid}), 32'd0);
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // CPU load from 0x10 -> word 4.
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h10;
        exp_acc(1'b0, 10'd4, 32'd0); q_crd.push_back(32'hA500_0004);
        @(negedge clk);
        chk("t1_stall", 32'(bus.cpu_stall), 32'd0);
        chk("t1_cmd_ready", 32'(bus.host_cmd_ready), 32'd1);
        step();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        step();
        // CPU store then load at 0x20 -> word 8.
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'hDEAD_BEEF;
        exp_acc(1'b1, 10'd8, 32'hDEAD_BEEF);
        step();
        bus.cpu_wr = 1'b0;
        exp_acc(1'b0, 10'd8, 32'd0); q_crd.push_back(32'hDEAD_BEEF);
        step();
        bus.cpu_req = 1'b0;
        step();

        // Host write burst across the address wrap.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_wr = 1'b1;
        bus.host_cmd_addr = 10'h3FE; bus.host_cmd_len = 10'd4;
        step();
        bus.host_cmd_valid = 1'b0; bus.host_wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.host_wdata = wd[i];
            exp_acc(1'b1, wa[i], wd[i]);
            @(negedge clk);
            chk("t2_wready", 32'(bus.host_wready), 32'd1);
            chk("t2_done_early", 32'(bus.host_done), 32'd0);
            step();
        end
        bus.host_wvalid = 1'b0;
        @(negedge clk);
        chk("t2_done", 32'(bus.host_done), 32'd1);
        chk("t2_ready_in_done", 32'(bus.host_cmd_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t2_done_clear", 32'(bus.host_done), 32'd0);
        chk("t2_ready_back", 32'(bus.host_cmd_ready), 32'd1);

        // Host read-back of the same four words.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_acc(1'b0, wa[i], 32'd0);
            q_hrd.push_back(wd[i]);
        end
        step();
        bus.host_cmd_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("t2r_done", 32'(bus.host_done), 32'd1);
        chk("t2r_done_with_rvalid", 32'(bus.host_rvalid), 32'd1);
        step();

        // Starvation: CPU holds the port, host read len 2 at 0x100.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_addr = 10'h100; bus.host_cmd_len = 10'd2;
        q_hrd.push_back(32'hA500_0100); q_hrd.push_back(32'hA500_0101);
        step();
        bus.host_cmd_valid = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            hs = (c == 4) || (c == 9);
            if (hs) exp_acc(1'b0, (c == 4) ? 10'h100 : 10'h101, 32'd0);
            else begin exp_acc(1'b0, 10'd4, 32'd0); q_crd.push_back(32'hA500_0004); end
            @(negedge clk);
            chk("t3_stall", 32'(bus.cpu_stall), 32'(hs));
            step();
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(bus.host_done), 32'd1);
        step();

        // Zero-length command.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_addr = 10'd0; bus.host_cmd_len = 10'd0;
        @(negedge clk);
        chk("t4_ready", 32'(bus.host_cmd_ready), 32'd1);
        step();
        @(negedge clk);
        chk("t4_done", 32'(bus.host_done), 32'd1);
        chk("t4_ready_in_done", 32'(bus.host_cmd_ready), 32'd0);
        chk("t4_mem_en", 32'(bus.mem_en), 32'd0);
        bus.host_cmd_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t4_ready_back", 32'(bus.host_cmd_ready), 32'd1);
        chk("t4_done_clear", 32'(bus.host_done), 32'd0);
        step();

        // Write burst with a 3-cycle wvalid gap while the CPU is active.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_wr = 1'b1;
        bus.host_cmd_addr = 10'h200; bus.host_cmd_len = 10'd3;
        step();
        bus.host_cmd_valid = 1'b0;
        bus.host_wvalid = 1'b1; bus.host_wdata = 32'h0000_0011;
        exp_acc(1'b1, 10'h200, 32'h0000_0011);
        @(negedge clk);
        chk("t5_wready_b0", 32'(bus.host_wready), 32'd1);
        step();
        bus.host_wvalid = 1'b0; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) begin bus.host_wvalid = 1'b1; bus.host_wdata = 32'h0000_0022; end
            exp_acc(1'b0, 10'd4, 32'd0); q_crd.push_back(32'hA500_0004);
            @(negedge clk);
            chk("t5_wready_lost", 32'(bus.host_wready), 32'd0);
            chk("t5_stall_lost", 32'(bus.cpu_stall), 32'd0);
            step();
        end
        exp_acc(1'b1, 10'h201, 32'h0000_0022);
        @(negedge clk);
        chk("t5_wready_b1", 32'(bus.host_wready), 32'd1);
        chk("t5_stall_b1", 32'(bus.cpu_stall), 32'd1);
        step();
        bus.cpu_req = 1'b0; bus.host_wdata = 32'h0000_0033;
        exp_acc(1'b1, 10'h202, 32'h0000_0033);
        @(negedge clk);
        chk("t5_wready_b2", 32'(bus.host_wready), 32'd1);
        step();
        bus.host_wvalid = 1'b0;
        @(negedge clk);
        chk("t5_done", 32'(bus.host_done), 32'd1);
        step();

        // Reset right after a host read grant discards the return.
        bus.host_cmd_valid = 1'b1; bus.host_cmd_wr = 1'b0;
        bus.host_cmd_addr = 10'h3FE; bus.host_cmd_len = 10'd2;
        step();
        bus.host_cmd_valid = 1'b0;
        exp_acc(1'b0, 10'h3FE, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1; bus.cpu_req = 1'b1;
        #1;
        chk("t6_stall_in_rst", 32'(bus.cpu_stall), 32'd1);
        chk("t6_mem_en_in_rst", 32'(bus.mem_en), 32'd0);
        chk("t6_ready_in_rst", 32'(bus.host_cmd_ready), 32'd0);
        step();
        chk("t6_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("t6_host_done", 32'(bus.host_done), 32'd0);
        bus.cpu_req = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_idle", 32'(bus.host_cmd_ready), 32'd1);
        chk("t6_mem_en_idle", 32'(bus.mem_en), 32'd0);
        chk("t6_done_idle", 32'(bus.host_done), 32'd0);
        step();
        @(negedge clk);
        chk("t6_done_later", 32'(bus.host_done), 32'd0);
        chk("t6_ready_later", 32'(bus.host_cmd_ready), 32'd1);

        chk("q_mem_drained", 32'(q_mem.size()), 32'd0);
        chk("q_cpu_rd_drained", 32'(q_crd.size()), 32'd0);
        chk("q_host_rd_drained", 32'(q_hrd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
